// File: rtl/axi_mem_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_mem_slave_pkg
// Shared types and constants for the AXI4 memory responder: FSM state
// encodings, AXI response codes, AXI burst type codes and a small helper that
// folds the write error flags into a single B response.
// Optional feature macro honoured by the design: AXI_MEM_SLAVE_DECERR_EN.
// -----------------------------------------------------------------------------
package axi_mem_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // A decode error outranks a slave error, which outranks a clean response.
  function automatic logic [1:0] pickResp(input logic decErr, input logic slvErr);
    if (decErr) begin
      return RESP_DECERR;
    end else if (slvErr) begin
      return RESP_SLVERR;
    end
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_mem_slave_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_mem_slave_addr_gen
// Combinational word-index stepper shared by the read and write FSMs.
// Ports:
//   i_idx       current word index (byte address already shifted down)
//   i_burst     AXI burst type of the transaction
//   o_nextIdx   index of the following beat
//   o_inRange   high when i_idx addresses a real word of the array
// -----------------------------------------------------------------------------
module axi_mem_slave_addr_gen
  import axi_mem_slave_pkg::*;
#(
  parameter int IDX_WIDTH = 29,
  parameter int MEM_DEPTH = 256
) (
  input  logic [IDX_WIDTH-1:0] i_idx,
  input  logic [1:0]           i_burst,
  output logic [IDX_WIDTH-1:0] o_nextIdx,
  output logic                 o_inRange
);

  localparam int DEPTH_BITS = $clog2(MEM_DEPTH);

  // FIXED bursts keep hammering the same word; WRAP is deliberately handled
  // like INCR, and the reserved encoding falls back to INCR as well.
  always_comb begin
    o_nextIdx = i_idx;
    case (i_burst)
      BURST_FIXED: o_nextIdx = i_idx;
      BURST_INCR:  o_nextIdx = i_idx + IDX_WIDTH'(1);
      BURST_WRAP:  o_nextIdx = i_idx + IDX_WIDTH'(1);
      default:     o_nextIdx = i_idx + IDX_WIDTH'(1);
    endcase
  end

  // Any set bit above the array's index width means the word does not exist.
  always_comb begin
    o_inRange = ((i_idx >> DEPTH_BITS) == '0);
  end

endmodule

// File: rtl/axi_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_mem_slave
// Single-clock AXI4 memory responder serving reads and writes from an internal
// word array. Independent read and write FSMs allow one outstanding burst per
// direction with full AR/R and AW/W/B concurrency.
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   aw_* / w_* / b_*      AXI4 write address, write data and write response
//   ar_* / r_*            AXI4 read address and read data
//   busy_o                high while either FSM is away from idle
// Optional feature: define AXI_MEM_SLAVE_DECERR_EN to answer out-of-range
// beats with DECERR (writes dropped, reads return zero). Without it the word
// index simply wraps modulo MEM_DEPTH.
// -----------------------------------------------------------------------------
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6,
  parameter int MEM_DEPTH      = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic [AXI_USER_WIDTH-1:0]   aw_user_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   w_user_i,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  output logic [AXI_USER_WIDTH-1:0]   b_user_o,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  input  logic [AXI_USER_WIDTH-1:0]   ar_user_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic [AXI_USER_WIDTH-1:0]   r_user_o,
  output logic                        busy_o
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = AXI_ADDR_WIDTH - OFF_BITS;
  localparam int DEPTH_BITS = $clog2(MEM_DEPTH);

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wr_state_e                 r_wrState;
  logic [AXI_ID_WIDTH-1:0]   r_wrId;
  logic [IDX_WIDTH-1:0]      r_wrIdx;
  logic [7:0]                r_wrLen;
  logic [7:0]                r_wrCnt;
  logic [1:0]                r_wrBurst;
  logic                      r_wrPast;
  logic                      r_wrSlvErr;
  logic                      r_wrDecErr;

  rd_state_e                 r_rdState;
  logic [AXI_ID_WIDTH-1:0]   r_rdId;
  logic [IDX_WIDTH-1:0]      r_rdNextIdx;
  logic [7:0]                r_rdLen;
  logic [7:0]                r_rdCnt;
  logic [1:0]                r_rdBurst;
  logic [AXI_DATA_WIDTH-1:0] r_rdData;
  logic [1:0]                r_rdResp;

  logic [IDX_WIDTH-1:0]      w_awIdx;
  logic [IDX_WIDTH-1:0]      w_arIdx;
  logic [IDX_WIDTH-1:0]      w_wrNextIdx;
  logic                      w_wrInRange;
  logic                      w_wrEn;
  logic [IDX_WIDTH-1:0]      w_rdCurIdx;
  logic [1:0]                w_rdCurBurst;
  logic [IDX_WIDTH-1:0]      w_rdNextIdx;
  logic                      w_rdInRange;
  logic [AXI_DATA_WIDTH-1:0] w_rdLoadData;
  logic [1:0]                w_rdLoadResp;

  // Low address bits below the beat size are dropped, so unaligned starts
  // behave exactly like the aligned word that contains them.
  assign w_awIdx = aw_addr_i[AXI_ADDR_WIDTH-1:OFF_BITS];
  assign w_arIdx = ar_addr_i[AXI_ADDR_WIDTH-1:OFF_BITS];

  // Handshake signals are squashed while reset is held so that nothing can
  // complete on the master side during reset.
  assign aw_ready_o = (r_wrState == W_IDLE) && !rst_i;
  assign w_ready_o  = (r_wrState == W_DATA) && !rst_i;
  assign b_valid_o  = (r_wrState == W_RESP) && !rst_i;
  assign ar_ready_o = (r_rdState == R_IDLE) && !rst_i;
  assign r_valid_o  = (r_rdState == R_DATA) && !rst_i;

  assign b_id_o   = r_wrId;
  assign b_resp_o = pickResp(r_wrDecErr, r_wrSlvErr);
  assign b_user_o = '0;
  assign r_id_o   = r_rdId;
  assign r_data_o = r_rdData;
  assign r_resp_o = r_rdResp;
  assign r_last_o = (r_rdCnt == r_rdLen);
  assign r_user_o = '0;
  assign busy_o   = (r_wrState != W_IDLE) || (r_rdState != R_IDLE);

  axi_mem_slave_addr_gen #(
    .IDX_WIDTH (IDX_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_wrAddrGen (
    .i_idx     (r_wrIdx),
    .i_burst   (r_wrBurst),
    .o_nextIdx (w_wrNextIdx),
    .o_inRange (w_wrInRange)
  );

  // While idle the read stepper looks at the incoming AR address so the first
  // beat can be loaded on the AR handshake; afterwards it looks at the index
  // of the beat that will be presented next.
  assign w_rdCurIdx   = (r_rdState == R_IDLE) ? w_arIdx : r_rdNextIdx;
  assign w_rdCurBurst = (r_rdState == R_IDLE) ? ar_burst_i : r_rdBurst;

  axi_mem_slave_addr_gen #(
    .IDX_WIDTH (IDX_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_rdAddrGen (
    .i_idx     (w_rdCurIdx),
    .i_burst   (w_rdCurBurst),
    .o_nextIdx (w_rdNextIdx),
    .o_inRange (w_rdInRange)
  );

`ifdef AXI_MEM_SLAVE_DECERR_EN
  // Out-of-range beats never touch the array and read back as zero/DECERR.
  assign w_wrEn = (r_wrState == W_DATA) && w_valid_i && !rst_i && !r_wrPast && w_wrInRange;

  always_comb begin
    w_rdLoadData = '0;
    w_rdLoadResp = RESP_DECERR;
    if (w_rdInRange) begin
      w_rdLoadData = r_mem[w_rdCurIdx[DEPTH_BITS-1:0]];
      w_rdLoadResp = RESP_OKAY;
    end
  end
`else
  // Without decode errors the index wraps modulo the array depth.
  assign w_wrEn = (r_wrState == W_DATA) && w_valid_i && !rst_i && !r_wrPast;

  always_comb begin
    w_rdLoadData = r_mem[w_rdCurIdx[DEPTH_BITS-1:0]];
    w_rdLoadResp = RESP_OKAY;
  end

  logic w_unusedRange;
  assign w_unusedRange = w_wrInRange | w_rdInRange;
`endif

  logic w_unusedInputs;
  assign w_unusedInputs = ^{aw_addr_i[OFF_BITS-1:0], ar_addr_i[OFF_BITS-1:0],
                            aw_size_i, ar_size_i, aw_user_i, ar_user_i, w_user_i};

  // Byte-enabled array write. The array has no reset so its contents survive
  // a reset pulse.
  always_ff @(posedge clk_i) begin
    if (w_wrEn) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_strb_i[b]) begin
          r_mem[r_wrIdx[DEPTH_BITS-1:0]][8*b +: 8] <= w_data_i[8*b +: 8];
        end
      end
    end
  end

  // Write FSM. Once the beat numbered len has been taken without w_last, the
  // burst is "past" its length: further beats are swallowed unwritten and the
  // counter stops, so the error check at w_last only needs the past flag and
  // a counter/len compare to catch both early and late w_last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrState  <= W_IDLE;
      r_wrId     <= '0;
      r_wrIdx    <= '0;
      r_wrLen    <= '0;
      r_wrCnt    <= '0;
      r_wrBurst  <= BURST_INCR;
      r_wrPast   <= 1'b0;
      r_wrSlvErr <= 1'b0;
      r_wrDecErr <= 1'b0;
    end else begin
      case (r_wrState)
        W_IDLE: begin
          if (aw_valid_i) begin
            r_wrId     <= aw_id_i;
            r_wrIdx    <= w_awIdx;
            r_wrLen    <= aw_len_i;
            r_wrBurst  <= aw_burst_i;
            r_wrCnt    <= '0;
            r_wrPast   <= 1'b0;
            r_wrSlvErr <= 1'b0;
            r_wrDecErr <= 1'b0;
            r_wrState  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_valid_i) begin
`ifdef AXI_MEM_SLAVE_DECERR_EN
            if (!r_wrPast && !w_wrInRange) begin
              r_wrDecErr <= 1'b1;
            end
`endif
            if (w_last_i) begin
              if (r_wrPast || (r_wrCnt != r_wrLen)) begin
                r_wrSlvErr <= 1'b1;
              end
              r_wrState <= W_RESP;
            end else if (r_wrCnt == r_wrLen) begin
              r_wrPast <= 1'b1;
            end else begin
              r_wrCnt <= r_wrCnt + 8'd1;
              r_wrIdx <= w_wrNextIdx;
            end
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            r_wrState <= W_IDLE;
          end
        end
        default: r_wrState <= W_IDLE;
      endcase
    end
  end

  // Read FSM. r_data is a true register loaded only on the AR handshake and
  // on each R handshake, so it holds steady under back-pressure even if the
  // word is rewritten meanwhile, and a same-edge write yields the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdState   <= R_IDLE;
      r_rdId      <= '0;
      r_rdNextIdx <= '0;
      r_rdLen     <= '0;
      r_rdCnt     <= '0;
      r_rdBurst   <= BURST_INCR;
      r_rdData    <= '0;
      r_rdResp    <= RESP_OKAY;
    end else begin
      case (r_rdState)
        R_IDLE: begin
          if (ar_valid_i) begin
            r_rdId      <= ar_id_i;
            r_rdLen     <= ar_len_i;
            r_rdBurst   <= ar_burst_i;
            r_rdCnt     <= '0;
            r_rdNextIdx <= w_rdNextIdx;
            r_rdData    <= w_rdLoadData;
            r_rdResp    <= w_rdLoadResp;
            r_rdState   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready_i) begin
            if (r_rdCnt == r_rdLen) begin
              r_rdState <= R_IDLE;
            end else begin
              r_rdCnt     <= r_rdCnt + 8'd1;
              r_rdNextIdx <= w_rdNextIdx;
              r_rdData    <= w_rdLoadData;
              r_rdResp    <= w_rdLoadResp;
            end
          end
        end
        default: r_rdState <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_slave
// Self-checking bench for axi_mem_slave: a table of single-beat write/read
// vectors with hand-computed results, followed by hand-written sequences for
// bursts, back-pressure, length mismatch, FIXED bursts and out-of-range
// addressing (AXI_MEM_SLAVE_DECERR_EN selects the expected bounds behaviour).
// -----------------------------------------------------------------------------
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awValid = 1'b0, awReady;
  logic [5:0]  awId = '0;
  logic [31:0] awAddr = '0;
  logic [7:0]  awLen = '0;
  logic [1:0]  awBurst = BURST_INCR;
  logic        wValid = 1'b0, wReady, wLast = 1'b0;
  logic [63:0] wData = '0;
  logic [7:0]  wStrb = '0;
  logic        bValid, bReady = 1'b0;
  logic [5:0]  bId, bUser;
  logic [1:0]  bResp;
  logic        arValid = 1'b0, arReady;
  logic [5:0]  arId = '0;
  logic [31:0] arAddr = '0;
  logic [7:0]  arLen = '0;
  logic [1:0]  arBurst = BURST_INCR;
  logic        rValid, rReady = 1'b0, rLast;
  logic [5:0]  rId, rUser;
  logic [63:0] rData;
  logic [1:0]  rResp;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [63:0] wBeatData [8];
  logic [7:0]  wBeatStrb [8];
  logic [63:0] rBeatData [8];
  logic [1:0]  rBeatResp [8];
  logic        rBeatLast [8];
  logic [5:0]  lastRid, lastBid;
  logic [1:0]  lastBresp;
  logic        wReadyAtAw;
  int          bLat, rLat;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] expData;
    logic [1:0]  expResp;
  } vec_t;

  vec_t vecs [15];

  axi_mem_slave dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(awValid), .aw_ready_o(awReady), .aw_id_i(awId), .aw_addr_i(awAddr),
    .aw_len_i(awLen), .aw_size_i(3'd3), .aw_burst_i(awBurst), .aw_user_i(6'd0),
    .w_valid_i(wValid), .w_ready_o(wReady), .w_data_i(wData), .w_strb_i(wStrb),
    .w_last_i(wLast), .w_user_i(6'd0),
    .b_valid_o(bValid), .b_ready_i(bReady), .b_id_o(bId), .b_resp_o(bResp), .b_user_o(bUser),
    .ar_valid_i(arValid), .ar_ready_o(arReady), .ar_id_i(arId), .ar_addr_i(arAddr),
    .ar_len_i(arLen), .ar_size_i(3'd3), .ar_burst_i(arBurst), .ar_user_i(6'd0),
    .r_valid_o(rValid), .r_ready_i(rReady), .r_id_o(rId), .r_data_o(rData),
    .r_resp_o(rResp), .r_last_o(rLast), .r_user_o(rUser),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got=no handshake want=handshake within 50 cycles", name);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic doWrite(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int nBeats);
    int waitCnt;
    awId = id; awAddr = addr; awLen = len; awBurst = burst; awValid = 1'b1;
    wReadyAtAw = wReady;
    waitCnt = 0;
    while (!awReady && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    if (!awReady) timeoutFail("awHandshake");
    @(negedge clk);
    awValid = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      wValid = 1'b1; wData = wBeatData[i]; wStrb = wBeatStrb[i]; wLast = (i == nBeats - 1);
      waitCnt = 0;
      while (!wReady && waitCnt < 50) begin @(negedge clk); waitCnt++; end
      if (!wReady) timeoutFail("wHandshake");
      @(negedge clk);
    end
    wValid = 1'b0; wLast = 1'b0;
    bReady = 1'b1;
    waitCnt = 0;
    while (!bValid && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    if (!bValid) timeoutFail("bHandshake");
    bLat = waitCnt; lastBresp = bResp; lastBid = bId;
    @(negedge clk);
    bReady = 1'b0;
  endtask

  task automatic doRead(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
    int waitCnt;
    arId = id; arAddr = addr; arLen = len; arBurst = burst; arValid = 1'b1;
    waitCnt = 0;
    while (!arReady && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    if (!arReady) timeoutFail("arHandshake");
    @(negedge clk);
    arValid = 1'b0;
    rReady = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      waitCnt = 0;
      while (!rValid && waitCnt < 50) begin @(negedge clk); waitCnt++; end
      if (!rValid) timeoutFail("rHandshake");
      if (i == 0) rLat = waitCnt;
      rBeatData[i] = rData; rBeatResp[i] = rResp; rBeatLast[i] = rLast; lastRid = rId;
      @(negedge clk);
    end
    rReady = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    if (v.isWrite) begin
      wBeatData[0] = v.data;
      wBeatStrb[0] = v.strb;
      doWrite(6'h01, v.addr, 8'd0, BURST_INCR, 1);
      checkOutput($sformatf("vec%0d bResp", idx), 64'(lastBresp), 64'(v.expResp));
    end else begin
      doRead(6'h02, v.addr, 8'd0, BURST_INCR);
      checkOutput($sformatf("vec%0d rData", idx), rBeatData[0], v.expData);
      checkOutput($sformatf("vec%0d rResp", idx), 64'(rBeatResp[0]), 64'(v.expResp));
      checkOutput($sformatf("vec%0d rLast", idx), 64'(rBeatLast[0]), 64'd1);
    end
  endtask

  initial begin
    int waitCnt;

    vecs[0]  = '{1'b1, 32'h100, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 64'h0, RESP_OKAY};
    vecs[1]  = '{1'b0, 32'h100, 64'h0, 8'h00, 64'hA5A5A5A5A5A5A5A5, RESP_OKAY};
    vecs[2]  = '{1'b1, 32'h104, 64'h0123456789ABCDEF, 8'h03, 64'h0, RESP_OKAY};
    vecs[3]  = '{1'b0, 32'h107, 64'h0, 8'h00, 64'hA5A5A5A5A5A5CDEF, RESP_OKAY};
    vecs[4]  = '{1'b1, 32'h1F8, 64'hDEADBEEF00C0FFEE, 8'hFF, 64'h0, RESP_OKAY};
    vecs[5]  = '{1'b1, 32'h1F8, 64'h1111111111111111, 8'h80, 64'h0, RESP_OKAY};
    vecs[6]  = '{1'b0, 32'h1F8, 64'h0, 8'h00, 64'h11ADBEEF00C0FFEE, RESP_OKAY};
    vecs[7]  = '{1'b0, 32'h100, 64'h0, 8'h00, 64'hA5A5A5A5A5A5CDEF, RESP_OKAY};
    vecs[8]  = '{1'b1, 32'h000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, RESP_OKAY};
    vecs[9]  = '{1'b1, 32'h000, 64'h0000000000000000, 8'h0F, 64'h0, RESP_OKAY};
    vecs[10] = '{1'b0, 32'h000, 64'h0, 8'h00, 64'hFFFFFFFF00000000, RESP_OKAY};
    vecs[11] = '{1'b1, 32'h7F8, 64'h5555555555555555, 8'hFF, 64'h0, RESP_OKAY};
    vecs[12] = '{1'b1, 32'h208, 64'h6565656565656565, 8'hFF, 64'h0, RESP_OKAY};
    vecs[13] = '{1'b1, 32'h0E8, 64'h2929292929292929, 8'hFF, 64'h0, RESP_OKAY};
    vecs[14] = '{1'b0, 32'h7F8, 64'h0, 8'h00, 64'h5555555555555555, RESP_OKAY};

    // Reset release: handshakes are squashed while reset is high and the
    // address channels open in the very first cycle after it falls.
    repeat (3) @(negedge clk);
    checkOutput("rstAwReadyHeld", 64'(awReady), 64'd0);
    checkOutput("rstArReadyHeld", 64'(arReady), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstAwReady", 64'(awReady), 64'd1);
    checkOutput("rstArReady", 64'(arReady), 64'd1);
    checkOutput("rstBValid", 64'(bValid), 64'd0);
    checkOutput("rstRValid", 64'(rValid), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // INCR burst write then read back, ids echoed and r_last only on beat 4.
    for (int i = 0; i < 4; i++) begin
      wBeatData[i] = 64'h11 * 64'(i + 1);
      wBeatStrb[i] = 8'hFF;
    end
    doWrite(6'h0A, 32'h40, 8'd3, BURST_INCR, 4);
    checkOutput("incrBResp", 64'(lastBresp), 64'(RESP_OKAY));
    checkOutput("incrBId", 64'(lastBid), 64'h0A);
    checkOutput("incrWReadyWithAw", 64'(wReadyAtAw), 64'd0);
    checkOutput("incrBLatency", 64'(bLat), 64'd0);
    checkOutput("incrBUser", 64'(bUser), 64'd0);
    doRead(6'h15, 32'h40, 8'd3, BURST_INCR);
    checkOutput("incrRId", 64'(lastRid), 64'h15);
    checkOutput("incrRLatency", 64'(rLat), 64'd0);
    checkOutput("incrRUser", 64'(rUser), 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("incrRData%0d", i), rBeatData[i], 64'h11 * 64'(i + 1));
      checkOutput($sformatf("incrRLast%0d", i), 64'(rBeatLast[i]), 64'(i == 3));
    end

    // R back-pressure while the pending word is rewritten.
    for (int i = 0; i < 4; i++) begin
      wBeatData[i] = 64'h1000 + 64'(i);
      wBeatStrb[i] = 8'hFF;
    end
    doWrite(6'h03, 32'h80, 8'd3, BURST_INCR, 4);
    wBeatData[0] = 64'hBEEF;
    arId = 6'h07; arAddr = 32'h80; arLen = 8'd3; arBurst = BURST_INCR; arValid = 1'b1;
    rReady = 1'b1;
    waitCnt = 0;
    while (!arReady && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    if (!arReady) timeoutFail("bpArHandshake");
    @(negedge clk);
    arValid = 1'b0;
    checkOutput("bpBeat0Valid", 64'(rValid), 64'd1);
    checkOutput("bpBeat0Data", rData, 64'h1000);
    @(negedge clk);
    rReady = 1'b0;
    checkOutput("bpBusy", 64'(busy), 64'd1);
    fork
      doWrite(6'h08, 32'h88, 8'd0, BURST_INCR, 1);
      begin
        for (int k = 0; k < 5; k++) begin
          checkOutput($sformatf("bpHold%0d", k), rData, 64'h1001);
          @(negedge clk);
        end
      end
    join
    checkOutput("bpWriteResp", 64'(lastBresp), 64'(RESP_OKAY));
    rReady = 1'b1;
    checkOutput("bpBeat1Data", rData, 64'h1001);
    checkOutput("bpBeat1Last", 64'(rLast), 64'd0);
    @(negedge clk);
    checkOutput("bpBeat2Data", rData, 64'h1002);
    @(negedge clk);
    checkOutput("bpBeat3Data", rData, 64'h1003);
    checkOutput("bpBeat3Last", 64'(rLast), 64'd1);
    @(negedge clk);
    rReady = 1'b0;
    checkOutput("bpDone", 64'(rValid), 64'd0);
    doRead(6'h09, 32'h88, 8'd0, BURST_INCR);
    checkOutput("bpNewWord", rBeatData[0], 64'hBEEF);

    // Early w_last: len 3 but only two beats.
    wBeatData[0] = 64'hC1; wBeatData[1] = 64'hC2;
    doWrite(6'h0C, 32'hC0, 8'd3, BURST_INCR, 2);
    checkOutput("shortBResp", 64'(lastBresp), 64'(RESP_SLVERR));
    checkOutput("shortNextAwReady", 64'(awReady), 64'd1);
    wBeatData[0] = 64'hD0;
    doWrite(6'h0D, 32'hD0, 8'd0, BURST_INCR, 1);
    checkOutput("afterShortBResp", 64'(lastBresp), 64'(RESP_OKAY));
    doRead(6'h0C, 32'hC0, 8'd1, BURST_INCR);
    checkOutput("shortData0", rBeatData[0], 64'hC1);
    checkOutput("shortData1", rBeatData[1], 64'hC2);

    // Extra beat beyond len 0: second beat must not reach word 0xE8.
    wBeatData[0] = 64'hAAAAAAAAAAAAAAAA; wBeatData[1] = 64'hBBBBBBBBBBBBBBBB;
    doWrite(6'h0E, 32'hE0, 8'd0, BURST_INCR, 2);
    checkOutput("longBResp", 64'(lastBresp), 64'(RESP_SLVERR));
    doRead(6'h0E, 32'hE0, 8'd1, BURST_INCR);
    checkOutput("longData0", rBeatData[0], 64'hAAAAAAAAAAAAAAAA);
    checkOutput("longData1", rBeatData[1], 64'h2929292929292929);

    // FIXED bursts stay on one word for both directions.
    wBeatData[0] = 64'h1; wBeatData[1] = 64'h2;
    doWrite(6'h10, 32'h200, 8'd1, BURST_FIXED, 2);
    checkOutput("fixedBResp", 64'(lastBresp), 64'(RESP_OKAY));
    doRead(6'h10, 32'h200, 8'd1, BURST_INCR);
    checkOutput("fixedWord0", rBeatData[0], 64'h2);
    checkOutput("fixedWord1", rBeatData[1], 64'h6565656565656565);
    doRead(6'h11, 32'h200, 8'd2, BURST_FIXED);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("fixedRead%0d", i), rBeatData[i], 64'h2);
    end

    // Out-of-range addressing, per beat, and a lone access at 0x800.
    doRead(6'h20, 32'h7F8, 8'd1, BURST_INCR);
    checkOutput("edgeBeat0Data", rBeatData[0], 64'h5555555555555555);
    checkOutput("edgeBeat0Resp", 64'(rBeatResp[0]), 64'(RESP_OKAY));
    doRead(6'h21, 32'h800, 8'd0, BURST_INCR);
`ifdef AXI_MEM_SLAVE_DECERR_EN
    checkOutput("oobData", rBeatData[0], 64'h0);
    checkOutput("oobResp", 64'(rBeatResp[0]), 64'(RESP_DECERR));
    doRead(6'h20, 32'h7F8, 8'd1, BURST_INCR);
    checkOutput("edgeBeat1Data", rBeatData[1], 64'h0);
    checkOutput("edgeBeat1Resp", 64'(rBeatResp[1]), 64'(RESP_DECERR));
    wBeatData[0] = 64'h1234; wBeatStrb[0] = 8'hFF;
    doWrite(6'h22, 32'h800, 8'd0, BURST_INCR, 1);
    checkOutput("oobWriteResp", 64'(lastBresp), 64'(RESP_DECERR));
    doRead(6'h23, 32'h000, 8'd0, BURST_INCR);
    checkOutput("oobWord0Kept", rBeatData[0], 64'hFFFFFFFF00000000);
`else
    checkOutput("oobData", rBeatData[0], 64'hFFFFFFFF00000000);
    checkOutput("oobResp", 64'(rBeatResp[0]), 64'(RESP_OKAY));
    doRead(6'h20, 32'h7F8, 8'd1, BURST_INCR);
    checkOutput("edgeBeat1Data", rBeatData[1], 64'hFFFFFFFF00000000);
    checkOutput("edgeBeat1Resp", 64'(rBeatResp[1]), 64'(RESP_OKAY));
`endif

    checkOutput("endBusy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
